rob_alloc: RTL
==============

ROB_ALLOC -- requirements
Module: rob_alloc

Interface
REQ-001 Parameter SZ, default `ROB_SZ, number of reorder-buffer entries; SHALL be a power of two, at least 4.
REQ-002 Parameter IDX_W, default $clog2(SZ), width of every entry index.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dispatch_valid  input  1  dispatch requests one entry this cycle.
REQ-006 dispatch_dest_reg  input  5  architectural destination register of the dispatched instruction; 0 means no destination.
REQ-007 dispatch_NPC  input  `XLEN  NPC of the dispatched instruction.
REQ-008 dispatch_ready  output  1  an entry can be accepted this cycle.
REQ-009 dispatch_rob_idx  output  IDX_W  index given to the instruction accepted this cycle (current tail).
REQ-010 move_head  input  1  retire stage frees the head entry this cycle.
REQ-011 clear_rob  input  1  flush: discard all entries (branch mispredict).
REQ-012 rob_head  output  IDX_W  index of the oldest occupied entry; feeds the retire stage.
REQ-013 head_dest_reg  output  5  dest_reg stored at rob_head.
REQ-014 head_NPC  output  `XLEN  NPC stored at rob_head.
REQ-015 head_valid  output  1  the entry at rob_head is occupied.
REQ-016 rob_count  output  IDX_W+1  number of occupied entries, 0..SZ.
REQ-017 rob_full  output  1  rob_count == SZ.
REQ-018 rob_empty  output  1  rob_count == 0.
REQ-019 underflow_err  output  1  sticky: move_head was seen while the buffer was empty.

Function
REQ-020 State: head pointer, tail pointer, count register, and per-entry {valid, dest_reg, NPC}; all updated only on the rising edge of clock.
REQ-021 dispatch_ready = ~rob_full & ~clear_rob; it is combinational from the current state and SHALL NOT consider a same-cycle move_head.
REQ-022 Accept = dispatch_valid & dispatch_ready; on accept: entry[tail] <= {1, dispatch_dest_reg, dispatch_NPC} and tail <= tail+1 mod SZ.
REQ-023 dispatch_rob_idx = tail every cycle, whether or not a request is accepted.
REQ-024 Retire = move_head & ~rob_empty & ~clear_rob; on retire: entry[head].valid <= 0 and head <= head+1 mod SZ.
REQ-025 count: on accept only, +1; on retire only, -1; on both in the same cycle, unchanged; on neither, unchanged.
REQ-026 Accept and retire in the same cycle, with count between 1 and SZ-1, SHALL both take effect; when the buffer is empty, only the accept takes effect.
REQ-027 Wrap-around: the pointer value SZ-1 advances to 0; rob_full and rob_empty SHALL be derived from count only, never from a pointer comparison.
REQ-028 move_head while rob_empty SHALL be ignored (no state change) and SHALL set underflow_err to 1; the flag holds until reset.
REQ-029 clear_rob SHALL, at the next edge, set head, tail and count to 0 and clear every valid bit; a dispatch or retire in the same cycle is discarded. underflow_err is unaffected.
REQ-030 rob_head = head; head_valid = entry[head].valid; head_dest_reg and head_NPC are read combinationally from entry[head].
REQ-031 Latency: an entry accepted at edge N is visible at rob_head/head_valid from edge N when the buffer was empty before N.
REQ-032 Invariant: head_valid == ~rob_empty in every cycle.

Reset
REQ-033 reset has priority over clear_rob, dispatch and move_head.
REQ-034 After reset: head = tail = 0, count = 0, all valid bits = 0, underflow_err = 0, rob_full = 0, rob_empty = 1, dispatch_ready = 1, head_valid = 0.
REQ-035 dest_reg and NPC storage need no reset; their contents are don't-care while valid = 0.
REQ-036 reset asserted while entries are occupied SHALL produce exactly the state in REQ-034 at the next edge.

Verification
REQ-037 SZ=8, reset, then 8 dispatches with NPC 0x4, 0x8, ... 0x20 and no retire -> dispatch_rob_idx 0..7, rob_full = 1, dispatch_ready = 0, and a 9th dispatch is dropped with count = 8.
REQ-038 Full buffer, dispatch_valid and move_head in the same cycle -> retire only: count = 7, head = 1, tail = 0; the next-cycle dispatch is accepted at index 0.
REQ-039 Wrap-around: 12 dispatches interleaved with 10 retires -> tail = 4, head = 2, count = 2, head_NPC = the NPC of the 11th instruction.
REQ-040 With 5 occupied entries, clear_rob together with dispatch_valid -> next cycle count = 0, head = tail = 0, head_valid = 0, and the dispatch is lost.
REQ-041 Empty buffer, move_head = 1 -> no pointer change, underflow_err = 1 and still 1 after a later clear_rob; it returns to 0 only on reset.
REQ-042 Empty buffer, dispatch and move_head in the same cycle -> count = 1, head = 0, head_valid = 1, and underflow_err = 1 (the move_head arrived while the buffer was empty).

Source files
------------

// File: rtl/rob_alloc.sv
// Reorder-buffer allocator: tracks head/tail/count and per-entry
// {valid, dest_reg, NPC} for dispatch and in-order retire.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef XLEN
`define XLEN 32
`endif

module rob_alloc #(
  parameter int SZ    = `ROB_SZ,
  parameter int IDX_W = $clog2(SZ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic [4:0]        dispatch_dest_reg,
  input  logic [`XLEN-1:0]  dispatch_NPC,
  output logic              dispatch_ready,
  output logic [IDX_W-1:0]  dispatch_rob_idx,
  input  logic              move_head,
  input  logic              clear_rob,
  output logic [IDX_W-1:0]  rob_head,
  output logic [4:0]        head_dest_reg,
  output logic [`XLEN-1:0]  head_NPC,
  output logic              head_valid,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_full,
  output logic              rob_empty,
  output logic              underflow_err
);

  localparam int CW = IDX_W + 1;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CW-1:0]    count;
  logic [SZ-1:0]    valid;
  logic [4:0]       dest_q [SZ];
  logic [`XLEN-1:0] npc_q  [SZ];
  logic             accept;
  logic             retire;

  // Full/empty come from count alone: head == tail is ambiguous.
  assign rob_full  = (count == CW'(SZ));
  assign rob_empty = (count == '0);

  assign dispatch_ready   = ~rob_full & ~clear_rob;
  assign dispatch_rob_idx = tail;
  assign accept = dispatch_valid & dispatch_ready;
  assign retire = move_head & ~rob_empty & ~clear_rob;

  assign rob_head      = head;
  assign rob_count     = count;
  assign head_valid    = valid[head];
  assign head_dest_reg = dest_q[head];
  assign head_NPC      = npc_q[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      valid         <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (move_head && rob_empty)
        underflow_err <= 1'b1;
      if (clear_rob) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        valid <= '0;
      end else begin
        if (accept) begin
          valid[tail] <= 1'b1;
          tail        <= tail + IDX_W'(1);
        end
        if (retire) begin
          valid[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        if (accept && !retire)
          count <= count + CW'(1);
        else if (retire && !accept)
          count <= count - CW'(1);
      end
    end
  end

  // Payload is meaningless while valid is low, so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      dest_q[tail] <= dispatch_dest_reg;
      npc_q[tail]  <= dispatch_NPC;
    end
  end

endmodule
